// File: rtl/cp_pkg.sv
// ---------------------------------------------------------------------------
// cp_pkg -- shared definitions for the MAC carry propagator.
//   CP_D_WIDTH     : default limb width W
//   CP_MAC_LATENCY : default multiply-accumulate core latency (ce cycles)
//   cp_state_e     : carry FSM states (RUN accepts limbs, FLUSH emits carry)
// ---------------------------------------------------------------------------
package cp_pkg;

    localparam int CP_D_WIDTH     = 72;
    localparam int CP_MAC_LATENCY = 6;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } cp_state_e;

endpackage : cp_pkg

// File: rtl/cp_sync_fifo.sv
// ---------------------------------------------------------------------------
// cp_sync_fifo -- single-clock FIFO with an occupancy count.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   push_i, data_i    : write request and data (ignored when full)
//   pop_i             : read request (ignored when empty)
//   data_o            : head entry (meaningful only when !empty_o)
//   empty_o           : no entries held
//   count_o           : number of entries held, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module cp_sync_fifo #(
    parameter  int WIDTH = 73,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // NOTE: sequential state is written with <= only, so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // The producer throttles itself; a push into a full buffer is a bug.
    push_overflow_a: assert property (@(posedge clk) disable iff (rst) !(push_i && full));

endmodule : cp_sync_fifo

// File: rtl/mac_carry_propagator.sv
// ---------------------------------------------------------------------------
// mac_carry_propagator -- turns a row of 2W-bit MAC partial products into a
// stream of W-bit limbs by adding the running carry to each product, then
// appending the final carry as the row's last limb.
// Ports:
//   clk, sclr          : clock, asynchronous active-high reset
//   in_valid, in_last  : operand issue to the MAC core, final limb of a row
//   in_ready           : issue accepted when in_valid && in_ready (= mac_ce)
//   mac_ce             : clock enable for the MAC core pipeline
//   mac_p              : MAC core product, aligned with the tag pipe output
//   out_limb/valid/last: result limb stream; out_ready pops it
// ---------------------------------------------------------------------------
module mac_carry_propagator #(
    parameter int CP_D_WIDTH  = cp_pkg::CP_D_WIDTH,
    parameter int MAC_LATENCY = cp_pkg::CP_MAC_LATENCY,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    sclr,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic                    mac_ce,
    input  logic [2*CP_D_WIDTH-1:0] mac_p,
    output logic [CP_D_WIDTH-1:0]   out_limb,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ready
);

    import cp_pkg::*;

    localparam int W     = CP_D_WIDTH;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    // Leaves room for one consume push plus the FLUSH push that may follow.
    localparam logic [CNT_W-1:0] CE_LIMIT = CNT_W'(FIFO_DEPTH - 2);

    cp_state_e              state_q, state_d;
    logic [W-1:0]           carry_q, carry_d;
    logic [MAC_LATENCY-1:0] tag_valid_q;
    logic [MAC_LATENCY-1:0] tag_last_q;
    logic [2*W-1:0]         sum;
    logic                   consume;
    logic                   fifo_push;
    logic [W:0]             fifo_wdata;
    logic [W:0]             fifo_head;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;

    assign mac_ce   = (state_q == ST_RUN) && (fifo_count <= CE_LIMIT);
    assign in_ready = mac_ce;

    // The last tag stage describes the product currently on mac_p.
    assign consume = tag_valid_q[MAC_LATENCY-1] && mac_ce;
    // Carry stays below 2^W, so this 2W-bit add cannot overflow.
    assign sum     = mac_p + {{W{1'b0}}, carry_q};

    // Tags advance in lockstep with the MAC core, i.e. only on ce.
    always_ff @(posedge clk or posedge sclr) begin
        if (sclr) begin
            tag_valid_q <= '0;
            tag_last_q  <= '0;
        end else if (mac_ce) begin
            tag_valid_q[0] <= in_valid;
            tag_last_q[0]  <= in_last;
            for (int i = 1; i < MAC_LATENCY; i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_last_q[i]  <= tag_last_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge sclr) begin
        if (sclr) begin
            state_q <= ST_RUN;
            carry_q <= '0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        carry_d    = carry_q;
        fifo_push  = 1'b0;
        fifo_wdata = '0;
        case (state_q)
            ST_RUN: begin
                if (consume) begin
                    fifo_push  = 1'b1;
                    fifo_wdata = {1'b0, sum[W-1:0]};
                    carry_d    = sum[2*W-1:W];
                    if (tag_last_q[MAC_LATENCY-1]) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                // mac_ce is low here, so nothing else competes for the push.
                fifo_push  = 1'b1;
                fifo_wdata = {1'b1, carry_q};
                carry_d    = '0;
                state_d    = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    cp_sync_fifo #(
        .WIDTH (W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (sclr),
        .push_i  (fifo_push),
        .data_i  (fifo_wdata),
        .pop_i   (out_valid && out_ready),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Gate the head so the outputs read zero while the buffer is empty.
    assign out_valid = !fifo_empty;
    assign out_limb  = out_valid ? fifo_head[W-1:0] : '0;
    assign out_last  = out_valid && fifo_head[W];

endmodule : mac_carry_propagator

// File: tb/tb_mac_carry_propagator.sv
// ---------------------------------------------------------------------------
// tb_mac_carry_propagator -- drives rows of MAC products into the carry
// propagator through a behavioural MAC pipeline and checks the limb stream
// against the big-integer value of each row.
// ---------------------------------------------------------------------------
module tb_mac_carry_propagator;

    localparam int W    = cp_pkg::CP_D_WIDTH;
    localparam int L    = cp_pkg::CP_MAC_LATENCY;
    localparam int D    = 8;
    localparam int BIGW = 6 * W;

    typedef logic [2*W-1:0] wide_t;
    typedef struct packed {
        logic [W-1:0] limb;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         sclr;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic         mac_ce;
    wide_t        mac_p;
    logic [W-1:0] out_limb;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;

    mac_carry_propagator #(
        .CP_D_WIDTH  (W),
        .MAC_LATENCY (L),
        .FIFO_DEPTH  (D)
    ) dut (
        .clk       (clk),
        .sclr      (sclr),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .mac_ce    (mac_ce),
        .mac_p     (mac_p),
        .out_limb  (out_limb),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    exp_t  exp_q[$];
    wide_t drv_p;
    wide_t row_p [8];
    int    row_first_cyc;
    int    ready_mode = 0;   // 0: always ready, 1: stalled, 2: random

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural MAC core: product of an accepted issue appears on mac_p
    // after L ce-enabled edges.
    wide_t mac_pipe [L];
    always @(posedge clk or posedge sclr) begin
        if (sclr) begin
            for (int i = 0; i < L; i++) mac_pipe[i] <= '0;
        end else if (mac_ce) begin
            mac_pipe[0] <= in_valid ? drv_p : '0;
            for (int i = 1; i < L; i++) mac_pipe[i] <= mac_pipe[i-1];
        end
    end
    assign mac_p = mac_pipe[L-1];

    task automatic check(input string name, input wide_t act, input wide_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Products shaped like a*b+c with W-bit operands keep the carry < 2^W.
    function automatic wide_t rand_p();
        logic [W-1:0] a, b, c;
        a = W'({$urandom, $urandom, $urandom});
        b = W'({$urandom, $urandom, $urandom});
        c = W'({$urandom, $urandom, $urandom});
        if ($urandom_range(0, 7) == 0) begin
            a = '1; b = '1; c = '1;
        end
        return wide_t'(a) * wide_t'(b) + wide_t'(c);
    endfunction

    // Reference: a row is the integer sum(p_i * 2^(W*i)); its limbs are the
    // n+1 base-2^W digits of that integer, the top one flagged last.
    task automatic push_expected(input int n);
        logic [BIGW-1:0] total;
        exp_t            e;
        total = '0;
        for (int i = 0; i < n; i++) total += BIGW'(row_p[i]) << (W * i);
        for (int k = 0; k <= n; k++) begin
            e.limb = total[W*k +: W];
            e.last = (k == n);
            exp_q.push_back(e);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue_limb(input wide_t p, input logic last);
        int waited;
        bit acc;
        waited   = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_last  = last;
        drv_p    = p;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (!acc) begin
                waited++;
                if (waited > 200) begin
                    fail("issue_timeout");
                    break;
                end
            end
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic issue_row(input int n);
        push_expected(n);
        for (int i = 0; i < n; i++) begin
            issue_limb(row_p[i], i == n - 1);
            if (i == 0) row_first_cyc = cyc;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) fail("drain_timeout");
        repeat (3) @(posedge clk);
        #1;
    endtask

    // out_ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor / scoreboard
    bit           lat_arm  = 1'b0;
    bit           lat_seen = 1'b0;
    int           lat_cyc;
    bit           ce_arm   = 1'b0;
    int           ce_low   = 0;
    bit           hold_valid = 1'b0;
    logic [W:0]   hold_val;
    bit           cnt_pend = 1'b0;
    exp_t         mon_e;

    always @(negedge clk) begin
        if (ce_arm && !mac_ce) ce_low++;

        if (cnt_pend) begin
            check("count_stable_at_full_minus_1", wide_t'(dut.fifo_count), wide_t'(D - 1));
            cnt_pend = 1'b0;
        end
        if (!sclr && dut.fifo_count == (D - 1) && dut.fifo_push && out_valid && out_ready)
            cnt_pend = 1'b1;

        if (!sclr && out_valid && !out_ready) begin
            if (hold_valid) check("hold_stable", wide_t'({out_last, out_limb}), wide_t'(hold_val));
            hold_valid = 1'b1;
            hold_val   = {out_last, out_limb};
        end else begin
            hold_valid = 1'b0;
        end

        if (!sclr && out_valid) begin
            if (lat_arm && !lat_seen) begin
                lat_seen = 1'b1;
                lat_cyc  = cyc;
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_limb");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("limb", wide_t'(out_limb), wide_t'(mon_e.limb));
                    check("last", wide_t'(out_last), wide_t'(mon_e.last));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        sclr     = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        drv_p    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", wide_t'(out_valid), '0);
        check("rst_out_last",  wide_t'(out_last),  '0);
        check("rst_out_limb",  wide_t'(out_limb),  '0);
        @(negedge clk) sclr = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_mac_ce",   wide_t'(mac_ce),   wide_t'(1));
        check("post_rst_in_ready", wide_t'(in_ready), wide_t'(1));

        // 3-limb row 5,7,9 -> 5,7,9,0(last); latency L+1 edges incl. accept edge
        lat_arm  = 1'b1;
        lat_seen = 1'b0;
        row_p[0] = 5; row_p[1] = 7; row_p[2] = 9;
        issue_row(3);
        drain();
        lat_arm = 1'b0;
        check("latency_edges", wide_t'(lat_cyc - row_first_cyc + 1), wide_t'(L + 1));

        // Max-path: 2 x (2^144-2^72) is 2^216-2^72 -> limbs 0, 2^72-1, 2^72-1(last)
        row_p[0] = {{W{1'b1}}, {W{1'b0}}};
        row_p[1] = {{W{1'b1}}, {W{1'b0}}};
        issue_row(2);
        drain();

        // 1-limb row 2^72+3 -> 3, 1(last); mac_ce low exactly for FLUSH
        ce_low   = 0;
        ce_arm   = 1'b1;
        row_p[0] = wide_t'(1) << W | wide_t'(3);
        issue_row(1);
        drain();
        ce_arm = 1'b0;
        check("flush_ce_low_cycles", wide_t'(ce_low), wide_t'(1));

        // Downstream stall for 20 cycles under back-to-back rows
        @(negedge clk) ready_mode = 1;
        @(posedge clk);
        #1;
        fork
            begin
                for (int r = 0; r < 4; r++) begin
                    for (int i = 0; i < 3; i++) row_p[i] = rand_p();
                    issue_row(3);
                end
            end
            begin
                repeat (20) @(posedge clk);
                @(negedge clk);
                check("stall_mac_ce_low",   wide_t'(mac_ce),    '0);
                check("stall_out_valid",    wide_t'(out_valid), wide_t'(1));
                ready_mode = 0;
            end
        join
        drain();

        // Reset mid-row with 3 tags in flight and limbs waiting in the buffer
        @(negedge clk) ready_mode = 1;
        @(posedge clk);
        #1;
        row_p[0] = rand_p();
        issue_row(1);
        for (int t = 0; t < 100 && !out_valid; t++) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 3; i++) issue_limb(rand_p(), 1'b0);
        check("pre_reset_out_valid", wide_t'(out_valid), wide_t'(1));
        #1;
        sclr = 1'b1;
        exp_q.delete();
        ready_mode = 0;
        #1;
        check("reset_out_valid", wide_t'(out_valid), '0);
        check("reset_out_last",  wide_t'(out_last),  '0);
        check("reset_out_limb",  wide_t'(out_limb),  '0);
        check("reset_mac_ce",    wide_t'(mac_ce),    wide_t'(1));
        @(posedge clk);
        @(negedge clk) sclr = 1'b0;
        @(posedge clk);
        #1;
        row_p[0] = 11; row_p[1] = 22;
        issue_row(2);
        drain();

        // Random rows with random downstream backpressure
        @(negedge clk) ready_mode = 2;
        @(posedge clk);
        #1;
        for (int r = 0; r < 60; r++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) row_p[i] = rand_p();
            issue_row(n);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        @(negedge clk) ready_mode = 0;
        drain();
        check("queue_empty_at_end", wide_t'(exp_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mac_carry_propagator
